// File: rtl/noc_pkt_tx_if.sv
// rtl/noc_pkt_tx_if.sv - descriptor, payload and fifo-write handshakes of the packet transmitter
interface noc_pkt_tx_if #(
    parameter int DSIZE     = 4,
    parameter int DEST_BITS = 2,
    parameter int LEN_BITS  = 2
);
    logic                 req_valid;
    logic                 req_ready;
    logic [DEST_BITS-1:0] req_dest;
    logic [LEN_BITS-1:0]  req_len;
    logic                 pay_valid;
    logic                 pay_ready;
    logic [DSIZE-1:0]     pay_data;
    logic                 fifo_full;
    logic                 fifo_write;
    logic [DSIZE-1:0]     fifo_item;
    logic                 busy;
    logic                 pkt_done;
    logic [7:0]           pkt_count;

    modport master (
        input  req_valid, req_dest, req_len, pay_valid, pay_data, fifo_full,
        output req_ready, pay_ready, fifo_write, fifo_item, busy, pkt_done, pkt_count
    );

    modport slave (
        output req_valid, req_dest, req_len, pay_valid, pay_data, fifo_full,
        input  req_ready, pay_ready, fifo_write, fifo_item, busy, pkt_done, pkt_count
    );
endinterface

// File: rtl/noc_pkt_tx.sv
// rtl/noc_pkt_tx.sv - head flit plus payload streamer into a router input fifo write port
module noc_pkt_tx #(
    parameter int DSIZE     = 4,
    parameter int DEST_BITS = 2,
    parameter int LEN_BITS  = 2
) (
    input  logic          clk,
    input  logic          reset,
    noc_pkt_tx_if.master  bus
);
    typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

    state_t               state, state_n;
    logic                 out_valid, out_valid_n;
    logic [DSIZE-1:0]     item, item_n;
    logic [DSIZE-1:0]     head_flit;
    logic [LEN_BITS-1:0]  remaining, remaining_n;
    logic                 done_r, done_n;
    logic [7:0]           count, count_n;
    logic                 fifo_write;
    logic                 pay_ready;
    logic                 pay_accept;

    always_comb begin
        head_flit = '0;
        head_flit[DSIZE-1 -: DEST_BITS] = bus.req_dest;
        head_flit[LEN_BITS-1:0]         = bus.req_len;
    end

    assign fifo_write = out_valid && !bus.fifo_full;
    // The output register refills in the same cycle it drains, so the head
    // and payload flits leave back to back when nothing stalls.
    assign pay_ready  = (state != IDLE) && (!out_valid || fifo_write) && (remaining != '0);
    assign pay_accept = bus.pay_valid && pay_ready;

    always_comb begin
        state_n     = state;
        out_valid_n = out_valid;
        item_n      = item;
        remaining_n = remaining;
        done_n      = 1'b0;
        count_n     = count;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    item_n      = head_flit;
                    out_valid_n = 1'b1;
                    remaining_n = bus.req_len;
                    state_n     = HEAD;
                end
            end
            HEAD, BODY: begin
                if (pay_accept) begin
                    item_n      = bus.pay_data;
                    out_valid_n = 1'b1;
                    remaining_n = remaining - LEN_BITS'(1);
                    state_n     = BODY;
                end else if (fifo_write) begin
                    out_valid_n = 1'b0;
                    if (remaining == '0) begin
                        done_n  = 1'b1;
                        count_n = count + 8'd1;
                        state_n = IDLE;
                    end else begin
                        state_n = BODY;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            item      <= '0;
            remaining <= '0;
            done_r    <= 1'b0;
            count     <= 8'd0;
        end else begin
            state     <= state_n;
            out_valid <= out_valid_n;
            item      <= item_n;
            remaining <= remaining_n;
            done_r    <= done_n;
            count     <= count_n;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.pay_ready  = pay_ready;
    assign bus.fifo_write = fifo_write;
    assign bus.fifo_item  = item;
    assign bus.busy       = (state != IDLE);
    assign bus.pkt_done   = done_r;
    assign bus.pkt_count  = count;
endmodule

// File: tb/tb_noc_pkt_tx.sv
// tb/tb_noc_pkt_tx.sv - directed scoreboard bench for noc_pkt_tx
module tb_noc_pkt_tx;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    noc_pkt_tx_if #(.DSIZE(4), .DEST_BITS(2), .LEN_BITS(2)) bus ();
    noc_pkt_tx #(.DSIZE(4), .DEST_BITS(2), .LEN_BITS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_cmp    = 0;
    int         n_fail   = 0;
    int         wr_count = 0;
    logic [3:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.fifo_write === 1'b1) begin
            wr_count++;
            chk("sb_expected_write", (exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("sb_flit", bus.fifo_item, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_pkt(input logic [1:0] dest, input logic [1:0] len,
                           input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                           input logic [7:0] vpat, input int stall,
                           output int offs, output bit done_seen, output bit busy_low,
                           output bit pr_seen);
        logic [3:0] d[3];
        int idx;
        d[0] = d0; d[1] = d1; d[2] = d2;
        idx = 0;
        exp_q.push_back({dest, len});
        for (int k = 0; k < int'(len); k++) exp_q.push_back(d[k]);
        bus.req_valid = 1'b1;
        bus.req_dest  = dest;
        bus.req_len   = len;
        tick();
        bus.req_valid = 1'b0;
        done_seen = 1'b0; busy_low = 1'b0; pr_seen = 1'b0; offs = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.pkt_done === 1'b1) begin
                done_seen = 1'b1;
                offs = i;
                break;
            end
            if (bus.busy !== 1'b1) busy_low = 1'b1;
            bus.fifo_full = (i < stall);
            bus.pay_valid = (idx < int'(len)) && ((i > 7) ? 1'b1 : vpat[i]);
            bus.pay_data  = d[(idx < 3) ? idx : 0];
            #1;
            if (bus.pay_ready === 1'b1) pr_seen = 1'b1;
            if (i < stall) begin
                chk("stall_no_write", bus.fifo_write, 0);
                chk("stall_item_held", bus.fifo_item, {dest, len});
            end
            if (bus.pay_valid && bus.pay_ready) idx++;
            tick();
        end
        bus.fifo_full = 1'b0;
        bus.pay_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  offs, w0, n_done;
        bit  done_seen, busy_low, pr_seen;

        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_dest = '0; bus.req_len = '0;
        bus.pay_valid = 1'b0; bus.pay_data = '0; bus.fifo_full = 1'b0;
        tick(); tick();
        chk("rst_fifo_write", bus.fifo_write, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_pay_ready", bus.pay_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_pkt_done", bus.pkt_done, 0);
        chk("rst_pkt_count", bus.pkt_count, 0);
        chk("rst_fifo_item", bus.fifo_item, 0);
        reset = 1'b1;
        tick();

        // basic: 0xA, 0x5, 0x9 back to back
        w0 = wr_count;
        run_pkt(2'd2, 2'd2, 4'h5, 4'h9, 4'h0, 8'hFF, 0, offs, done_seen, busy_low, pr_seen);
        chk("basic_done", done_seen, 1);
        chk("basic_done_cycle", offs, 3);
        chk("basic_writes", wr_count - w0, 3);
        chk("basic_sb_empty", exp_q.size(), 0);
        chk("basic_count", bus.pkt_count, 1);
        chk("basic_req_ready", bus.req_ready, 1);
        chk("basic_busy_low", busy_low, 0);
        tick();

        // zero length: single 0xC, payload never requested
        w0 = wr_count;
        run_pkt(2'd3, 2'd0, 4'h7, 4'h7, 4'h7, 8'hFF, 0, offs, done_seen, busy_low, pr_seen);
        chk("zero_done_cycle", offs, 1);
        chk("zero_pay_ready", pr_seen, 0);
        chk("zero_writes", wr_count - w0, 1);
        chk("zero_count", bus.pkt_count, 2);
        tick();

        // backpressure: 4 full cycles right after head is presented
        w0 = wr_count;
        run_pkt(2'd1, 2'd3, 4'h1, 4'h2, 4'h3, 8'hFF, 4, offs, done_seen, busy_low, pr_seen);
        chk("stall_done_cycle", offs, 8);
        chk("stall_writes", wr_count - w0, 4);
        chk("stall_sb_empty", exp_q.size(), 0);
        chk("stall_count", bus.pkt_count, 3);
        tick();

        // payload bubbles 1,0,1,0,1
        w0 = wr_count;
        run_pkt(2'd2, 2'd3, 4'h1, 4'h2, 4'h3, 8'hF5, 0, offs, done_seen, busy_low, pr_seen);
        chk("bubble_done_cycle", offs, 6);
        chk("bubble_writes", wr_count - w0, 4);
        chk("bubble_busy_low", busy_low, 0);
        chk("bubble_count", bus.pkt_count, 4);
        tick();

        // reset after head plus one payload
        w0 = wr_count;
        exp_q.push_back(4'h3);
        exp_q.push_back(4'hE);
        bus.req_valid = 1'b1; bus.req_dest = 2'd0; bus.req_len = 2'd3;
        tick();
        bus.req_valid = 1'b0;
        bus.pay_valid = 1'b1; bus.pay_data = 4'hE;
        tick();
        bus.pay_data = 4'hF;
        chk("mid_count_before", bus.pkt_count, 4);
        reset = 1'b0;
        tick();
        chk("mid_fifo_write", bus.fifo_write, 0);
        chk("mid_req_ready", bus.req_ready, 1);
        chk("mid_busy", bus.busy, 0);
        chk("mid_count", bus.pkt_count, 0);
        chk("mid_pkt_done", bus.pkt_done, 0);
        chk("mid_pay_ready", bus.pay_ready, 0);
        bus.pay_valid = 1'b0;
        tick();
        chk("mid_pkt_done_after", bus.pkt_done, 0);
        chk("mid_writes", wr_count - w0, 2);
        chk("mid_sb_empty", exp_q.size(), 0);
        reset = 1'b1;
        tick();

        // 256 back-to-back zero-length packets wrap the counter
        for (int k = 0; k < 256; k++) exp_q.push_back(4'h4);
        bus.req_valid = 1'b1; bus.req_dest = 2'd1; bus.req_len = 2'd0;
        n_done = 0;
        for (int i = 0; i < 1000 && n_done < 256; i++) begin
            tick();
            if (bus.pkt_done === 1'b1) n_done++;
        end
        bus.req_valid = 1'b0;
        chk("wrap_done_count", n_done, 256);
        chk("wrap_count_zero", bus.pkt_count, 0);
        chk("wrap_sb_empty", exp_q.size(), 0);
        tick();
        run_pkt(2'd1, 2'd0, 4'h0, 4'h0, 4'h0, 8'hFF, 0, offs, done_seen, busy_low, pr_seen);
        chk("wrap_257_done", done_seen, 1);
        chk("wrap_257_count", bus.pkt_count, 1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
